// File: rtl/dram_pkg.sv
// dram_pkg: shared constants, bank-index helper and request bundle for the banked data RAM.
package dram_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH_WORDS = 2048;
    localparam int DEF_N_BANKS = 4;
    localparam int DEF_N_MASTERS = 2;

    // A single bank needs no select bits; callers widen zero to one for signal declarations.
    function automatic int bank_w(input int n_banks);
        return (n_banks > 1) ? $clog2(n_banks) : 0;
    endfunction

    typedef struct packed {
        logic we;
        logic [DEF_DATA_W/8-1:0] be;
        logic [$clog2(DEF_DEPTH_WORDS)-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } req_t;
endpackage

// File: rtl/dram_bank_spram.sv
// dram_bank_spram: behavioural single-port SRAM with byte enables and registered read data.
module dram_bank_spram #(
    parameter int DATA_W = 32,
    parameter int ROW_W = 9
) (
    input  logic CLK,
    input  logic CEB,
    input  logic WEB,
    input  logic [ROW_W-1:0] A,
    input  logic [DATA_W-1:0] D,
    input  logic [DATA_W/8-1:0] BE,
    output logic [DATA_W-1:0] Q
);
    logic [DATA_W-1:0] mem [1 << ROW_W];

    always_ff @(posedge CLK)
        if (!CEB) begin
            if (!WEB) begin
                for (int i = 0; i < DATA_W / 8; i++)
                    if (BE[i]) mem[A][i*8 +: 8] <= D[i*8 +: 8];
            end else
                Q <= mem[A];
        end
endmodule

// File: rtl/dram_banked.sv
// dram_banked: multi-master word-interleaved banked data RAM with per-bank round-robin arbitration.
module dram_banked
    import dram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int N_BANKS = DEF_N_BANKS,
    parameter int N_MASTERS = DEF_N_MASTERS,
    parameter int ADDR_W = $clog2(DEPTH_WORDS)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [N_MASTERS-1:0] m_req,
    output logic [N_MASTERS-1:0] m_gnt,
    input  logic [N_MASTERS-1:0] m_we,
    input  logic [N_MASTERS-1:0][DATA_W/8-1:0] m_be,
    input  logic [N_MASTERS-1:0][ADDR_W-1:0] m_addr,
    input  logic [N_MASTERS-1:0][DATA_W-1:0] m_wdata,
    output logic [N_MASTERS-1:0] m_rvalid,
    output logic [N_MASTERS-1:0][DATA_W-1:0] m_rdata
);
    localparam int BANK_W = bank_w(N_BANKS);
    localparam int BW = (BANK_W > 0) ? BANK_W : 1;
    localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int ROW_W = ADDR_W - BANK_W;

    logic [N_MASTERS-1:0][BW-1:0] m_bank, r_bank;
    logic [N_BANKS-1:0][MW-1:0] ptr, sel;
    logic [N_BANKS-1:0] b_gnt;
    logic [N_BANKS-1:0][DATA_W-1:0] b_q;
    logic [MW-1:0] idx;

    always_comb
        for (int m = 0; m < N_MASTERS; m++)
            m_bank[m] = (N_BANKS > 1) ? m_addr[m][BW-1:0] : '0;

    // Scanning from the far end of the cyclic order lets the nearest requester overwrite the others.
    always_comb begin
        b_gnt = '0;
        sel = '0;
        idx = '0;
        m_gnt = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            for (int k = N_MASTERS - 1; k >= 0; k--) begin
                idx = MW'((int'(ptr[b]) + k) % N_MASTERS);
                if (m_req[idx] && m_bank[idx] == BW'(b)) begin
                    b_gnt[b] = 1'b1;
                    sel[b] = idx;
                end
            end
            if (b_gnt[b]) m_gnt[sel[b]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ptr <= '0;
            r_bank <= '0;
            m_rvalid <= '0;
        end else begin
            for (int b = 0; b < N_BANKS; b++)
                if (b_gnt[b]) ptr[b] <= (sel[b] == MW'(N_MASTERS - 1)) ? '0 : sel[b] + MW'(1);
            for (int m = 0; m < N_MASTERS; m++)
                if (m_gnt[m]) r_bank[m] <= m_bank[m];
            m_rvalid <= m_gnt;
        end

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        dram_bank_spram #(.DATA_W(DATA_W), .ROW_W(ROW_W)) u_bank (
            .CLK(clk),
            .CEB(~b_gnt[b]),
            .WEB(~m_we[sel[b]]),
            .A(m_addr[sel[b]][ADDR_W-1:BANK_W]),
            .D(m_wdata[sel[b]]),
            .BE(m_be[sel[b]]),
            .Q(b_q[b])
        );
    end

    for (genvar m = 0; m < N_MASTERS; m++) begin : g_resp
        assign m_rdata[m] = b_q[r_bank[m]];
    end
endmodule

// File: tb/tb_dram_banked.sv
// tb_dram_banked: directed scoreboard bench for the banked data RAM at default parameters.
module tb_dram_banked;
    import dram_pkg::*;

    localparam int NM = DEF_N_MASTERS;
    localparam int DW = DEF_DATA_W;
    localparam int AW = $clog2(DEF_DEPTH_WORDS);
    localparam int NBY = DW / 8;

    typedef struct {
        logic rd;
        logic [DW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NM-1:0] m_req = '0;
    logic [NM-1:0] m_we = '0;
    logic [NM-1:0][NBY-1:0] m_be = '0;
    logic [NM-1:0][AW-1:0] m_addr = '0;
    logic [NM-1:0][DW-1:0] m_wdata = '0;
    logic [NM-1:0] m_gnt, m_rvalid;
    logic [NM-1:0][DW-1:0] m_rdata;

    logic [DW-1:0] mdl [DEF_DEPTH_WORDS];
    exp_t sb [NM][$];
    int checks = 0;
    int errors = 0;
    int c0 = 0;
    int c1 = 0;

    dram_banked dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_gnt(m_gnt), .m_we(m_we), .m_be(m_be),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic req_t wr(input int a, input logic [DW-1:0] d, input logic [NBY-1:0] be);
        return '{we: 1'b1, be: be, addr: AW'(a), wdata: d};
    endfunction

    function automatic req_t rd(input int a);
        return '{we: 1'b0, be: '0, addr: AW'(a), wdata: '0};
    endfunction

    task automatic drive(input int m, input req_t r);
        m_req[m] = 1'b1;
        m_we[m] = r.we;
        m_be[m] = r.be;
        m_addr[m] = r.addr;
        m_wdata[m] = r.wdata;
    endtask

    // One clock: check grants, update the scoreboard and model, then check the responses.
    task automatic step(input string tag, input logic [NM-1:0] eg);
        exp_t e;
        #1;
        chk({tag, " gnt"}, DW'(m_gnt), DW'(eg));
        for (int m = 0; m < NM; m++)
            if (eg[m]) sb[m].push_back('{rd: !m_we[m], d: mdl[m_addr[m]]});
        for (int m = 0; m < NM; m++)
            if (eg[m] && m_we[m])
                for (int i = 0; i < NBY; i++)
                    if (m_be[m][i]) mdl[m_addr[m]][i*8 +: 8] = m_wdata[m][i*8 +: 8];
        @(posedge clk);
        #1;
        for (int m = 0; m < NM; m++) begin
            chk($sformatf("%s rvalid%0d", tag, m), DW'(m_rvalid[m]), DW'(sb[m].size() != 0));
            if (sb[m].size() != 0) begin
                e = sb[m].pop_front();
                if (e.rd) chk($sformatf("%s rdata%0d", tag, m), m_rdata[m], e.d);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset rvalid", DW'(m_rvalid), '0);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(0, wr(i, 32'hC0DE_0000 | DW'(i * 32'h111), 4'hF));
            step("preload", 2'b01);
        end
        drive(0, wr(5, 32'hDEADBEEF, 4'hF));
        step("wr5", 2'b01);
        drive(0, rd(5));
        step("rd5", 2'b01);
        chk("rd5 const", m_rdata[0], 32'hDEADBEEF);
        drive(0, wr(5, 32'h11223344, 4'b0101));
        step("wr be0101", 2'b01);
        drive(0, rd(5));
        step("rd be0101", 2'b01);
        chk("be merge const", m_rdata[0], 32'hDE22BE44);
        drive(0, wr(5, 32'h0, 4'h0));
        step("wr be0", 2'b01);
        drive(0, rd(5));
        step("rd be0", 2'b01);
        chk("be0 const", m_rdata[0], 32'hDE22BE44);
        drive(0, rd(0));
        drive(1, rd(1));
        step("parallel", 2'b11);
        m_req = '0;
        for (int i = 0; i < 8; i++) begin
            drive(0, rd(i));
            step("stream", 2'b01);
        end
        m_req = '0;
        step("idle", 2'b00);
        drive(0, rd(4));
        #1;
        chk("midop gnt", DW'(m_gnt), DW'(2'b01));
        @(posedge clk);
        #1;
        chk("midop rvalid", DW'(m_rvalid[0]), DW'(1));
        chk("midop rdata", m_rdata[0], mdl[4]);
        rst_n = 1'b0;
        m_req = '0;
        #1;
        chk("async reset rvalid", DW'(m_rvalid), '0);
        for (int m = 0; m < NM; m++) sb[m].delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, rd(5));
        step("persist", 2'b01);
        chk("persist const", m_rdata[0], 32'hDE22BE44);
        m_req = '0;
        drive(0, rd(4));
        drive(1, rd(8));
        for (int i = 0; i < 100; i++) begin
            #1;
            c0 += int'(m_gnt[0]);
            c1 += int'(m_gnt[1]);
            step("rr", (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        m_req = '0;
        step("drain", 2'b00);
        chk("no starvation", DW'(c0 - c1 <= 1 && c1 - c0 <= 1 && c0 + c1 == 100), DW'(1));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
